cos_issue_ctrl: RTL and testbench

- Initiator and collector for the fixed-latency pipelined single-precision cosine core (sta/theta in, done_sig/cos_theta out, 36-cycle latency, no backpressure).
- Accepts a valid/ready stream of angles and launches one core operation per accepted angle.
- Buffers returning results in a FIFO and presents them as a valid/ready result stream.
- Uses credits so the core, which cannot stall, never returns a result with no room for it; supports a flush.

---
 rtl/cos_issue_ctrl_pkg.sv | 19 +
 rtl/cos_res_fifo.sv | 60 ++++++
 rtl/cos_issue_ctrl.sv | 161 ++++++++++++++++
 tb/tb_cos_issue_ctrl.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cos_issue_ctrl_pkg.sv
// Shared definitions for the cosine-core issue controller: word width, core latency, FSM encoding.
// Optional tag support in the controller is enabled with the COS_ISSUE_TAG_EN macro.
`ifndef SINGLE
`define SINGLE 32
`endif

package cos_issue_ctrl_pkg;

    localparam int SINGLE_W     = `SINGLE;
    localparam int CORE_LAT_DEF = 36;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ACTIVE     = 2'd1,
        FLUSH_WAIT = 2'd2,
        FLUSH_CLR  = 2'd3
    } issue_state_e;

endpackage

// File: rtl/cos_res_fifo.sv
// First-word-fall-through result FIFO with occupancy count and synchronous clear.
// A write to a full FIFO is accepted only when a read frees a slot in the same cycle.
module cos_res_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int AW     = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              empty,
    output logic              full,
    output logic [AW:0]       count
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_wr;
    logic              do_rd;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= rd_ptr + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // storage is pure data: no reset, qualified by count on the read side
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/cos_issue_ctrl.sv
// Issue/collect controller for a fixed-latency, non-stalling cosine core, with credit-based
// result buffering and flush. Define COS_ISSUE_TAG_EN to carry a per-angle tag to the result.
module cos_issue_ctrl
    import cos_issue_ctrl_pkg::*;
#(
    parameter int CORE_LAT   = CORE_LAT_DEF,
    parameter int FIFO_DEPTH = 64,
    parameter int FIFO_AW    = 6,
    parameter int TAG_W      = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [SINGLE_W-1:0] in_theta,
`ifdef COS_ISSUE_TAG_EN
    input  logic [TAG_W-1:0]    in_tag,
    output logic [TAG_W-1:0]    res_tag,
`endif
    output logic                in_ready,
    input  logic                flush,
    output logic                core_sta,
    output logic [SINGLE_W-1:0] core_theta,
    input  logic [SINGLE_W-1:0] core_cos,
    input  logic                core_done,
    output logic                res_valid,
    output logic [SINGLE_W-1:0] res_cos,
    input  logic                res_ready,
    output logic                busy,
    output logic                err
);

`ifdef COS_ISSUE_TAG_EN
    localparam int FIFO_W = SINGLE_W + TAG_W;
`else
    localparam int FIFO_W = SINGLE_W;
`endif
    localparam logic [FIFO_AW+1:0] CREDIT_MAX = (FIFO_AW+2)'(FIFO_DEPTH);

    issue_state_e        state;
    issue_state_e        state_nxt;
    logic [FIFO_AW:0]    inflight;
    logic [FIFO_AW:0]    fifo_count;
    logic [FIFO_AW+1:0]  credit;
    logic                accept;
    logic                done_ok;
    logic                fifo_rd;
    logic                fifo_clr;
    logic                fifo_empty;
    logic                fifo_full;
    logic [FIFO_W-1:0]   fifo_wdata;
    logic [FIFO_W-1:0]   fifo_rdata;
    logic                vld_p1;
    logic [SINGLE_W-1:0] theta_p1;

    assign credit  = {1'b0, inflight} + {1'b0, fifo_count};
    assign accept  = in_valid && in_ready;
    // a done with nothing outstanding is a protocol error; it is not stored so credits stay exact
    assign done_ok = core_done && (inflight != '0);

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        res_valid = 1'b0;
        fifo_rd   = 1'b0;
        fifo_clr  = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                in_ready  = (credit < CREDIT_MAX) && !flush;
                res_valid = !fifo_empty;
                fifo_rd   = res_valid && res_ready;
                if (accept) state_nxt = ACTIVE;
            end
            ACTIVE: begin
                in_ready  = (credit < CREDIT_MAX) && !flush;
                res_valid = !fifo_empty;
                fifo_rd   = res_valid && res_ready;
                if (flush)                           state_nxt = FLUSH_WAIT;
                else if (credit == '0 && !accept)    state_nxt = IDLE;
            end
            FLUSH_WAIT: begin
                fifo_rd = !fifo_empty;
                if (inflight == '0) state_nxt = FLUSH_CLR;
            end
            FLUSH_CLR: begin
                fifo_clr  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // issue stage: start pulse and angle registered one cycle after accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            theta_p1 <= '0;
        end else begin
            vld_p1 <= accept;
            if (accept) theta_p1 <= in_theta;
        end
    end

    assign core_sta   = vld_p1;
    assign core_theta = theta_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inflight <= '0;
            err      <= 1'b0;
        end else begin
            case ({accept, done_ok})
                2'b10:   inflight <= inflight + (FIFO_AW+1)'(1);
                2'b01:   inflight <= inflight - (FIFO_AW+1)'(1);
                default: inflight <= inflight;
            endcase
            if (core_done && ((inflight == '0) || (fifo_full && !fifo_rd))) err <= 1'b1;
        end
    end

`ifdef COS_ISSUE_TAG_EN
    logic [TAG_W-1:0] tag_dly [CORE_LAT+1];

    // tag delay line: stage CORE_LAT lines up with core_done for the same angle
    always_ff @(posedge clk) begin
        tag_dly[0] <= in_tag;
        for (int i = 1; i <= CORE_LAT; i++) tag_dly[i] <= tag_dly[i-1];
    end

    assign fifo_wdata = {tag_dly[CORE_LAT], core_cos};
    assign res_tag    = res_valid ? fifo_rdata[FIFO_W-1:SINGLE_W] : '0;
`else
    assign fifo_wdata = core_cos;
`endif

    cos_res_fifo #(
        .DATA_W (FIFO_W),
        .DEPTH  (FIFO_DEPTH),
        .AW     (FIFO_AW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .clr     (fifo_clr),
        .wr_en   (done_ok),
        .wr_data (fifo_wdata),
        .rd_en   (fifo_rd),
        .rd_data (fifo_rdata),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .count   (fifo_count)
    );

    // memory contents are unreset, so the result word is gated to zero when not presented
    assign res_cos = res_valid ? fifo_rdata[SINGLE_W-1:0] : '0;

endmodule

// File: tb/tb_cos_issue_ctrl.sv
// Directed bench for cos_issue_ctrl with a 36-cycle cosine-core stub and an in-order scoreboard.
`timescale 1ns/1ps
module tb_cos_issue_ctrl;

    localparam int LAT = 36;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_theta;
    logic        in_ready;
    logic        flush;
    logic        core_sta;
    logic [31:0] core_theta;
    logic [31:0] core_cos;
    logic        core_done;
    logic        res_valid;
    logic [31:0] res_cos;
    logic        res_ready;
    logic        busy;
    logic        err;
    logic        inj_done;
`ifdef COS_ISSUE_TAG_EN
    logic [7:0]  in_tag;
    logic [7:0]  res_tag;
    logic [7:0]  tag_q[$];
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int unexp = 0;
    int sta_cnt = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    cos_issue_ctrl dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_theta(in_theta),
`ifdef COS_ISSUE_TAG_EN
        .in_tag(in_tag), .res_tag(res_tag),
`endif
        .in_ready(in_ready), .flush(flush), .core_sta(core_sta), .core_theta(core_theta),
        .core_cos(core_cos), .core_done(core_done), .res_valid(res_valid), .res_cos(res_cos),
        .res_ready(res_ready), .busy(busy), .err(err)
    );

    function automatic logic [31:0] cos_model(input logic [31:0] t);
        if (t == 32'h0) return 32'h3F800000;
        return {t[15:0], t[31:16]} ^ 32'h5A5A0F0F;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // core stub: fixed latency, clears with the shared reset
    logic [LAT-1:0] sta_sr;
    logic [31:0]    cos_sr [LAT];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            sta_sr <= '0;
        end else begin
            sta_sr    <= {sta_sr[LAT-2:0], core_sta};
            cos_sr[0] <= cos_model(core_theta);
            for (int i = 1; i < LAT; i++) cos_sr[i] <= cos_sr[i-1];
        end
    end
    assign core_done = sta_sr[LAT-1] | inj_done;
    assign core_cos  = cos_sr[LAT-1];

    always @(negedge clk) begin
        if (!rst) begin
            if (core_sta) sta_cnt++;
            if (in_valid && in_ready) begin
                exp_q.push_back(cos_model(in_theta));
`ifdef COS_ISSUE_TAG_EN
                tag_q.push_back(in_tag);
`endif
            end
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    unexp++;
                end else begin
                    check_eq("sb_res_cos", {32'h0, res_cos}, {32'h0, exp_q.pop_front()});
`ifdef COS_ISSUE_TAG_EN
                    check_eq("sb_res_tag", {56'h0, res_tag}, {56'h0, tag_q.pop_front()});
`endif
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_sb();
        exp_q.delete();
`ifdef COS_ISSUE_TAG_EN
        tag_q.delete();
`endif
    endtask

    initial begin
        int lat, nr, acc, v, n;
        rst = 1'b1; in_valid = 1'b0; in_theta = '0; flush = 1'b0; res_ready = 1'b0; inj_done = 1'b0;
`ifdef COS_ISSUE_TAG_EN
        in_tag = '0;
`endif
        repeat (3) step();
        rst = 1'b0;
        step();
        check_eq("rst_in_ready", {63'h0, in_ready}, 64'd1);
        check_eq("rst_res_valid", {63'h0, res_valid}, 64'd0);
        check_eq("rst_core_sta", {63'h0, core_sta}, 64'd0);
        check_eq("rst_core_theta", {32'h0, core_theta}, 64'd0);
        check_eq("rst_res_cos", {32'h0, res_cos}, 64'd0);
        check_eq("rst_busy_err", {62'h0, busy, err}, 64'd0);

        // single angle, end-to-end latency
        res_ready = 1'b1;
        in_valid = 1'b1; in_theta = 32'h0;
        step();
        in_valid = 1'b0;
        check_eq("t1_core_sta", {63'h0, core_sta}, 64'd1);
        check_eq("t1_core_theta", {32'h0, core_theta}, 64'h0);
        step();
        check_eq("t1_sta_pulse", {63'h0, core_sta}, 64'd0);
        lat = 2;
        while (!res_valid && lat < 100) begin step(); lat++; end
        check_eq("t1_latency", 64'(lat), 64'd38);
        check_eq("t1_res_cos", {32'h0, res_cos}, 64'h3F800000);
        step();
        check_eq("t1_popped", {63'h0, res_valid}, 64'd0);
        repeat (2) step();
        check_eq("t1_busy_idle", {63'h0, busy}, 64'd0);

        // 100-angle stream at full rate
        sta_cnt = 0; nr = 0;
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1; in_theta = 32'h40000000 + 32'(i * 7);
            if (!in_ready) nr++;
            step();
        end
        in_valid = 1'b0;
        repeat (60) step();
        check_eq("t2_not_ready_cycles", 64'(nr), 64'd0);
        check_eq("t2_sta_count", 64'(sta_cnt), 64'd100);
        check_eq("t2_all_results", 64'(exp_q.size()), 64'd0);
        check_eq("t2_err", {63'h0, err}, 64'd0);

        // backpressure: credits cap accepts at the FIFO depth
        res_ready = 1'b0; acc = 0;
        for (int i = 0; i < 80; i++) begin
            in_valid = 1'b1; in_theta = 32'h3E000000 + 32'(i);
            if (in_ready) acc++;
            step();
        end
        check_eq("t3_accepts", 64'(acc), 64'd64);
        check_eq("t3_in_ready_low", {63'h0, in_ready}, 64'd0);
        in_valid = 1'b0;
        repeat (40) step();
        check_eq("t3_res_valid", {63'h0, res_valid}, 64'd1);
        res_ready = 1'b1; v = 0;
        for (int i = 0; i < 70; i++) begin
            if (res_valid) v++;
            step();
        end
        check_eq("t3_fifo_held", 64'(v), 64'd64);
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1; in_theta = 32'h3C000000 + 32'(i);
            if (in_ready) acc++;
            step();
        end
        in_valid = 1'b0;
        repeat (60) step();
        check_eq("t3_resume", 64'(acc), 64'd20);
        check_eq("t3_drained", 64'(exp_q.size()), 64'd0);
        check_eq("t3_err_busy", {62'h0, err, busy}, 64'd0);

        // flush with 20 results in flight
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1; in_theta = 32'h41000000 + 32'(i);
            step();
        end
        in_valid = 1'b0;
        repeat (4) step();
        flush = 1'b1;
        #1;
        check_eq("t4_ready_flush", {63'h0, in_ready}, 64'd0);
        clear_sb();
        step();
        flush = 1'b0;
        check_eq("t4_flush_wait", {62'h0, busy, in_ready}, 64'b10);
        n = 0; v = 0;
        while (busy && n < 200) begin
            if (res_valid) v++;
            step();
            n++;
        end
        check_eq("t4_cycles_to_idle", 64'(n), 64'd34);
        check_eq("t4_res_valid_cnt", 64'(v), 64'd0);
        v = 0;
        for (int i = 0; i < 20; i++) begin
            if (res_valid) v++;
            step();
        end
        check_eq("t4_no_stale", 64'(v), 64'd0);
        in_valid = 1'b1; in_theta = 32'h3F000000;
        step();
        in_valid = 1'b0;
        repeat (45) step();
        check_eq("t4_fresh_result", 64'(exp_q.size()), 64'd0);

        // reset while results are in flight
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_theta = 32'h42000000 + 32'(i);
            step();
        end
        in_valid = 1'b0;
        repeat (10) step();
        rst = 1'b1; #2 rst = 1'b0;
        clear_sb();
        v = 0;
        for (int i = 0; i < 50; i++) begin
            if (res_valid) v++;
            step();
        end
        check_eq("t5_no_res_after_rst", 64'(v), 64'd0);
        check_eq("t5_idle_ready", {62'h0, busy, in_ready}, 64'b01);

        // spurious core_done sets sticky err
        inj_done = 1'b1;
        step();
        inj_done = 1'b0;
        check_eq("t6_err_set", {63'h0, err}, 64'd1);
        check_eq("t6_no_write", {63'h0, res_valid}, 64'd0);
        repeat (5) step();
        check_eq("t6_err_sticky", {63'h0, err}, 64'd1);
        rst = 1'b1; #2 rst = 1'b0;
        #1;
        check_eq("t6_err_cleared", {63'h0, err}, 64'd0);
        check_eq("t6_rst_outputs", {62'h0, res_valid, in_ready}, 64'b01);

`ifdef COS_ISSUE_TAG_EN
        step();
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_theta = 32'h43000000 + 32'(i); in_tag = 8'(i);
            step();
        end
        in_valid = 1'b0;
        repeat (50) step();
        check_eq("t7_tags_drained", 64'(exp_q.size()), 64'd0);
        check_eq("t7_res_tag_idle", {56'h0, res_tag}, 64'd0);
`endif

        check_eq("unexpected_results", 64'(unexp), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
